// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals seen by mem_arbiter; slave = arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    output i_ack, i_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rd,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_we, mem_a, mem_wd, busy
  );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; req[0]=fetch, req[1]=data.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    // On a tie the port that did not win last time goes first.
    gnt_id    = (req == 2'b11) ? ~last : req[OWN_D];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between fetch and data ports.
// Optional access counters enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_i_cnt,
  output logic [15:0] stat_d_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  owner_t           r_owner, r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_i_rdata, r_d_rdata, r_mem_wd;
  logic [AW-1:0]    r_mem_a;

  logic             w_gnt_valid, w_gnt_id, w_grant;
  logic             w_access, w_last_cycle, w_ack_i, w_ack_d;
  logic [AW-1:0]    w_acc_addr;
  logic [DW-1:0]    w_acc_wd;

  rr_pick2 u_pick (
    .req       ({bus.d_req, bus.i_req}),
    .last      (r_last),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: if (r_cnt == '0) w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_access     = (r_state == ST_ACCESS);
  assign w_last_cycle = w_access && (r_cnt == '0);
  assign w_ack_i      = (r_state == ST_ACK) && (r_owner == OWN_I);
  assign w_ack_d      = (r_state == ST_ACK) && (r_owner == OWN_D);
  assign w_acc_addr   = (r_owner == OWN_D) ? bus.d_addr : bus.i_addr;
  assign w_acc_wd     = (r_owner == OWN_D) ? bus.d_wdata : r_mem_wd;

  // Memory bus follows the owner live during ACCESS and holds the last value elsewhere.
  assign bus.mem_a   = w_access ? w_acc_addr : r_mem_a;
  assign bus.mem_wd  = w_access ? w_acc_wd : r_mem_wd;
  assign bus.mem_we  = w_last_cycle && (r_owner == OWN_D) && bus.d_we;
  assign bus.i_ack   = w_ack_i;
  assign bus.d_ack   = w_ack_d;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.busy    = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner   <= OWN_I;
      r_last    <= OWN_D;
      r_cnt     <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_mem_a   <= '0;
      r_mem_wd  <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= owner_t'(w_gnt_id);
        r_last  <= owner_t'(w_gnt_id);
        r_cnt   <= CNT_LOAD;
      end
      if (w_access) begin
        r_mem_a  <= w_acc_addr;
        r_mem_wd <= w_acc_wd;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_last_cycle) begin
        if (r_owner == OWN_I)  r_i_rdata <= bus.mem_rd;
        else if (!bus.d_we)    r_d_rdata <= bus.mem_rd;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stat_i_cnt, r_stat_d_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_i_cnt <= '0;
      r_stat_d_cnt <= '0;
    end else begin
      if (w_ack_i && (r_stat_i_cnt != '1)) r_stat_i_cnt <= r_stat_i_cnt + 16'd1;
      if (w_ack_d && (r_stat_d_cnt != '1)) r_stat_d_cnt <= r_stat_d_cnt + 16'd1;
    end
  end

  assign stat_i_cnt = r_stat_i_cnt;
  assign stat_d_cnt = r_stat_d_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: WAIT_CYCLES=1 vector table plus
// latency (WAIT_CYCLES=4) and reset-during-store (WAIT_CYCLES=3) sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus3 ();
  mem_arbiter_if #(.AW(32), .DW(32)) bus4 ();

`ifdef MEM_ARB_STATS_EN
  logic [15:0] st1_i, st1_d, st3_i, st3_d, st4_i, st4_d;
`endif

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_cnt(st1_i), .stat_d_cnt(st1_d)
`endif
  );

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_cnt(st3_i), .stat_d_cnt(st3_d)
`endif
  );

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
`ifdef MEM_ARB_STATS_EN
    , .stat_i_cnt(st4_i), .stat_d_cnt(st4_d)
`endif
  );

  // Shared behavioural memory: combinational read per port, write on posedge.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign bus1.mem_rd = mem[bus1.mem_a[5:0]];
  assign bus3.mem_rd = mem[bus3.mem_a[5:0]];
  assign bus4.mem_rd = mem[bus4.mem_a[5:0]];

  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr]           <= pl_data;
    if (bus1.mem_we) mem[bus1.mem_a[5:0]]   <= bus1.mem_wd;
    if (bus3.mem_we) mem[bus3.mem_a[5:0]]   <= bus3.mem_wd;
    if (bus4.mem_we) mem[bus4.mem_a[5:0]]   <= bus4.mem_wd;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_we;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a[5:0];
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_w1(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int wes,
                        output int other);
    logic got;
    got = 1'b0; lat = 0; wes = 0; other = 0;
    if (port) begin
      bus1.d_req = 1'b1; bus1.d_we = we; bus1.d_addr = addr; bus1.d_wdata = wdata;
    end else begin
      bus1.i_req = 1'b1; bus1.i_addr = addr;
    end
    for (int c = 1; c <= 20 && !got; c++) begin
      if (bus1.mem_we) wes++;
      if (port ? bus1.i_ack : bus1.d_ack) other++;
      if (port ? bus1.d_ack : bus1.i_ack) begin
        got = 1'b1;
        lat = c;
      end
      if (!got) tick();
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    tick();
  endtask

  initial begin
    int lat, wes, other, n, bcnt, got;
    logic ack_port [4];
    int   ack_cyc  [4];

    bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
    bus4.i_req = 0; bus4.i_addr = '0; bus4.d_req = 0; bus4.d_we = 0; bus4.d_addr = '0; bus4.d_wdata = '0;

    //          port we    addr   wdata          exp_rd         exp_we
    vt[0] = '{1'b0, 1'b0, 32'd5,  32'h0,         32'hDEADBEEF,  0};
    vt[1] = '{1'b1, 1'b1, 32'd10, 32'h12345678,  32'h00000000,  1};
    vt[2] = '{1'b1, 1'b0, 32'd10, 32'h0,         32'h12345678,  0};
    vt[3] = '{1'b0, 1'b0, 32'd10, 32'h0,         32'h12345678,  0};
    vt[4] = '{1'b1, 1'b0, 32'd6,  32'h0,         32'h0BADF00D,  0};
    vt[5] = '{1'b1, 1'b1, 32'd6,  32'hAAAA5555,  32'h0BADF00D,  1};
    vt[6] = '{1'b0, 1'b0, 32'd6,  32'h0,         32'hAAAA5555,  0};
    vt[7] = '{1'b0, 1'b0, 32'd7,  32'h0,         32'hCAFEBABE,  0};

    tick();
    preload(5, 32'hDEADBEEF);
    preload(6, 32'h0BADF00D);
    preload(7, 32'hCAFEBABE);
    preload(10, 32'h0);
    preload(20, 32'h11112222);
    do_reset();

    check("rst_busy",    {31'd0, bus1.busy},   32'd0);
    check("rst_i_ack",   {31'd0, bus1.i_ack},  32'd0);
    check("rst_d_ack",   {31'd0, bus1.d_ack},  32'd0);
    check("rst_mem_we",  {31'd0, bus1.mem_we}, 32'd0);
    check("rst_mem_a",   bus1.mem_a,   32'd0);
    check("rst_mem_wd",  bus1.mem_wd,  32'd0);
    check("rst_i_rdata", bus1.i_rdata, 32'd0);
    check("rst_d_rdata", bus1.d_rdata, 32'd0);

    for (int v = 0; v < 8; v++) begin
      run_w1(vt[v].port, vt[v].we, vt[v].addr, vt[v].wdata, lat, wes, other);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("v%0d_mem_we_pulses", v), 32'(wes), 32'(vt[v].exp_we));
      check($sformatf("v%0d_wrong_port_ack", v), 32'(other), 32'd0);
      check($sformatf("v%0d_rdata", v), vt[v].port ? bus1.d_rdata : bus1.i_rdata, vt[v].exp_rd);
      check($sformatf("v%0d_mem_a_hold", v), bus1.mem_a, vt[v].addr);
      check($sformatf("v%0d_idle", v), {31'd0, bus1.busy}, 32'd0);
      if (vt[v].we) check($sformatf("v%0d_stored", v), mem[vt[v].addr[5:0]], vt[v].wdata);
    end

    // Both requesters held from reset: I wins first, then strict alternation.
    do_reset();
    bus1.i_req = 1'b1; bus1.i_addr = 32'd5;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'd7;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      if (bus1.i_ack && n < 4) begin ack_port[n] = 1'b0; ack_cyc[n] = c; n++; end
      if (bus1.d_ack && n < 4) begin ack_port[n] = 1'b1; ack_cyc[n] = c; n++; end
      if (n < 4) tick();
    end
    bus1.i_req = 1'b0; bus1.d_req = 1'b0;
    tick();
    check("rr_ack_count", 32'(n), 32'd4);
    for (int k = 0; k < 4 && k < n; k++) begin
      check($sformatf("rr_owner%0d", k), {31'd0, ack_port[k]}, {31'd0, (k % 2) == 1});
      check($sformatf("rr_cycle%0d", k), 32'(ack_cyc[k]), 32'(3 * (k + 1)));
    end
    check("rr_i_rdata", bus1.i_rdata, 32'hDEADBEEF);
    check("rr_d_rdata", bus1.d_rdata, 32'hCAFEBABE);

    // WAIT_CYCLES=4 load: ack in cycle 6, busy in 5 of those cycles.
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_addr = 32'd7;
    got = 0; lat = 0; bcnt = 0; wes = 0;
    for (int c = 1; c <= 20 && got == 0; c++) begin
      if (bus4.busy)   bcnt++;
      if (bus4.mem_we) wes++;
      if (bus4.d_ack) begin got = 1; lat = c; end
      if (got == 0) tick();
    end
    bus4.d_req = 1'b0;
    tick();
    check("w4_latency", 32'(lat), 32'd6);
    check("w4_busy_cycles", 32'(bcnt), 32'd5);
    check("w4_mem_we", 32'(wes), 32'd0);
    check("w4_d_rdata", bus4.d_rdata, 32'hCAFEBABE);

    // WAIT_CYCLES=3 store interrupted by reset in its second ACCESS cycle.
    bus3.d_req = 1'b1; bus3.d_we = 1'b1; bus3.d_addr = 32'd20; bus3.d_wdata = 32'h33334444;
    tick();
    tick();
    check("w3_busy_before_rst", {31'd0, bus3.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("w3_rst_busy",   {31'd0, bus3.busy},   32'd0);
    check("w3_rst_mem_we", {31'd0, bus3.mem_we}, 32'd0);
    bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    tick();
    reset = 1'b0;
    wes = 0; other = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus3.mem_we) wes++;
      if (bus3.d_ack)  other++;
      tick();
    end
    check("w3_post_mem_we", 32'(wes), 32'd0);
    check("w3_post_ack", 32'(other), 32'd0);
    check("w3_word_kept", mem[20], 32'h11112222);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    check("st_i_reset", {16'd0, st1_i}, 32'd0);
    for (int k = 0; k < 3; k++) run_w1(1'b0, 1'b0, 32'd5, 32'h0, lat, wes, other);
    for (int k = 0; k < 2; k++) run_w1(1'b1, 1'b0, 32'd7, 32'h0, lat, wes, other);
    check("st_i_cnt", {16'd0, st1_i}, 32'd3);
    check("st_d_cnt", {16'd0, st1_d}, 32'd2);
    force u_dut1.r_stat_i_cnt = 16'hFFFE;
    tick();
    release u_dut1.r_stat_i_cnt;
    for (int k = 0; k < 2; k++) run_w1(1'b0, 1'b0, 32'd5, 32'h0, lat, wes, other);
    check("st_i_sat", {16'd0, st1_i}, 32'h0000FFFF);
    check("st_d_kept", {16'd0, st1_d}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
